uart_rx: RTL and testbench

Serial receive half of the UART: recovers 8N1-style frames from the `rx` line by 16× oversampling, driven by the one-cycle `s_tick` strobe from the baud-rate timer. It sits between the pad-side `rx` input and the receive FIFO or host logic. It presents each assembled byte with a one-cycle `rx_done_tick` plus a per-frame framing error flag (and a parity error flag when parity support is compiled in).

---
 rtl/uart_rx.sv | 110 +++++++++++
 tb/tb_uart_rx.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampling UART receiver; start bit, DBIT data bits LSB first, optional even parity bit, stop bit.
// Ports: clk; reset (asynchronous, active high); s_tick (16x baud strobe, one clk wide); rx (serial line, idle high);
//        dout (last received word); rx_done_tick (one-cycle pulse per frame); frame_err (stop bit sampled 0);
//        parity_err (even-parity mismatch, constant 0 unless UART_RX_PARITY_EN is defined).
// Build option: define UART_RX_PARITY_EN to insert one even-parity bit between the data bits and the stop bit.
module uart_rx #(
  parameter int DBIT = 8,
  parameter int SB_TICK = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            rx,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            frame_err,
  output logic            parity_err
);
  localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam logic [SW-1:0] S_MID = SW'(7);
  localparam logic [SW-1:0] S_BIT = SW'(15);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [2:0] N_LAST = 3'(DBIT - 1);
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3, PARITY = 3'd4} state_t;
  localparam state_t AFTER_DATA = PARITY;
  logic p;
`else
  typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3} state_t;
  localparam state_t AFTER_DATA = STOP;
`endif
  state_t          state;
  logic [1:0]      sync;
  logic            rxs;
  logic [SW-1:0]   s;
  logic [2:0]      n;
  logic [DBIT-1:0] b;
  assign rxs = sync[1];
`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync <= 2'b11;
      state <= IDLE;
      s <= '0;
      n <= '0;
      b <= '0;
      dout <= '0;
      rx_done_tick <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      p <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      sync <= {sync[0], rx};
      rx_done_tick <= 1'b0;
      case (state)
        // start detection is immediate so the mid-bit sample lands within one tick of the edge
        IDLE:
          if (!rxs) begin
            state <= START;
            s <= '0;
          end
        // a line that is high again at mid start bit was a glitch
        START:
          if (s_tick) begin
            if (s == S_MID) begin
              state <= rxs ? IDLE : DATA;
              s <= '0;
              n <= '0;
            end else s <= s + 1'b1;
          end
        DATA:
          if (s_tick) begin
            if (s == S_BIT) begin
              s <= '0;
              b <= {rxs, b[DBIT-1:1]};
              if (n == N_LAST) state <= AFTER_DATA;
              else n <= n + 1'b1;
            end else s <= s + 1'b1;
          end
`ifdef UART_RX_PARITY_EN
        PARITY:
          if (s_tick) begin
            if (s == S_BIT) begin
              p <= rxs;
              s <= '0;
              state <= STOP;
            end else s <= s + 1'b1;
          end
`endif
        // data is delivered even on a framing error; a held-low line restarts from IDLE
        STOP:
          if (s_tick) begin
            if (s == S_STOP) begin
              dout <= b;
              frame_err <= ~rxs;
`ifdef UART_RX_PARITY_EN
              parity_err <= (^b) ^ p;
`endif
              rx_done_tick <= 1'b1;
              state <= IDLE;
            end else s <= s + 1'b1;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: self-checking bench for uart_rx; directed frame table, glitch/reset sequences, random frames vs a frame-level model.
module tb_uart_rx;
  localparam int DBIT = 8;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic s_tick = 1'b0;
  logic rx = 1'b1;
  logic [DBIT-1:0] dout;
  logic rx_done_tick, frame_err, parity_err;
  int tdiv = 10;
  int checks = 0;
  int failures = 0;
  int npulse = 0;
  int dbl = 0;
  logic prev = 1'b0;
  typedef struct {logic [7:0] d; logic fe; logic pe;} rec_t;
  rec_t got[$];
  typedef struct {logic [7:0] d; logic stop; logic par; int gap; logic [7:0] e_d; logic e_fe; logic e_pe;} vec_t;
  vec_t tv[7];

  uart_rx #(.DBIT(DBIT), .SB_TICK(16)) dut (
    .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx),
    .dout(dout), .rx_done_tick(rx_done_tick), .frame_err(frame_err), .parity_err(parity_err)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    repeat (tdiv - 1) @(posedge clk);
    #1 s_tick = 1'b1;
    @(posedge clk);
    #1 s_tick = 1'b0;
  end

  always @(negedge clk) begin
    rec_t r;
    if (rx_done_tick === 1'b1) begin
      r.d = dout;
      r.fe = frame_err;
      r.pe = parity_err;
      got.push_back(r);
      if (prev) dbl++;
    end
    prev = rx_done_tick;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, got=%0d pulses", got.size());
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic wait_ticks(input int k);
    for (int i = 0; i < k; i++) do @(posedge clk); while (s_tick !== 1'b1);
  endtask

  task automatic send_bits(input logic v, input int k);
    #1 rx = v;
    wait_ticks(k);
  endtask

  // a 0 stop bit is released early so the receiver's break restart meets an idle line at its mid-start sample
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
    send_bits(1'b0, 16);
    for (int i = 0; i < DBIT; i++) send_bits(d[i], 16);
    if (PAR_EN) send_bits(par, 16);
    if (stop) send_bits(1'b1, 16);
    else begin
      send_bits(1'b0, 12);
      send_bits(1'b1, 4);
    end
  endtask

  task automatic expect_frame(input string nm, input logic [7:0] d, input logic fe, input logic pe);
    chk({nm, " pulses"}, got.size(), npulse + 1);
    if (got.size() > npulse) begin
      chk({nm, " dout"}, {24'd0, got[npulse].d}, {24'd0, d});
      chk({nm, " frame_err"}, {31'd0, got[npulse].fe}, {31'd0, fe});
      chk({nm, " parity_err"}, {31'd0, got[npulse].pe}, {31'd0, pe});
    end
    npulse = got.size();
  endtask

  initial begin
    logic [7:0] d;
    logic stop, par;
    tv[0] = '{8'h55, 1'b1, 1'b0, 2, 8'h55, 1'b0, 1'b0};
    tv[1] = '{8'hA3, 1'b0, 1'b0, 2, 8'hA3, 1'b1, 1'b0};
    tv[2] = '{8'h0F, 1'b1, 1'b0, 3, 8'h0F, 1'b0, 1'b0};
    tv[3] = '{8'h00, 1'b1, 1'b1, 1, 8'h00, 1'b0, 1'b1};
    tv[4] = '{8'hFF, 1'b1, 1'b0, 0, 8'hFF, 1'b0, 1'b0};
    tv[5] = '{8'h07, 1'b1, 1'b1, 0, 8'h07, 1'b0, 1'b0};
    tv[6] = '{8'h07, 1'b1, 1'b0, 0, 8'h07, 1'b0, 1'b1};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset dout", {24'd0, dout}, 32'd0);
    chk("reset rx_done_tick", {31'd0, rx_done_tick}, 32'd0);
    chk("reset frame_err", {31'd0, frame_err}, 32'd0);
    chk("reset parity_err", {31'd0, parity_err}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      send_bits(1'b1, tv[i].gap);
      send_frame(tv[i].d, tv[i].stop, tv[i].par);
      expect_frame($sformatf("vec%0d", i), tv[i].e_d, tv[i].e_fe, PAR_EN ? tv[i].e_pe : 1'b0);
    end
    send_bits(1'b0, 3);
    send_bits(1'b1, 32);
    chk("glitch pulses", got.size(), npulse);
    chk("glitch dout held", {24'd0, dout}, 32'h07);
    send_bits(1'b0, 16);
    send_bits(1'b0, 16);
    send_bits(1'b0, 16);
    send_bits(1'b1, 16);
    send_bits(1'b1, 8);
    #2 reset = 1'b1;
    @(negedge clk);
    chk("midframe reset dout", {24'd0, dout}, 32'd0);
    chk("midframe reset frame_err", {31'd0, frame_err}, 32'd0);
    rx = 1'b1;
    reset = 1'b0;
    wait_ticks(40);
    chk("aborted frame pulses", got.size(), npulse);
    send_frame(8'h3C, 1'b1, 1'b0);
    expect_frame("after reset", 8'h3C, 1'b0, PAR_EN ? 1'b0 : 1'b0);
    tdiv = 4;
    send_bits(1'b1, 4);
    for (int i = 0; i < 40; i++) begin
      d = 8'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      par = 1'($urandom);
      send_bits(1'b1, $urandom_range(0, 5));
      send_frame(d, stop, par);
      expect_frame($sformatf("rand%0d", i), d, ~stop, PAR_EN ? ((^d) ^ par) : 1'b0);
    end
    send_bits(1'b1, 20);
    chk("no extra pulses", got.size(), npulse);
    chk("pulse width", dbl, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
